car_bank: RTL

CAR_BANK -- requirements
Module: car_bank

---
 rtl/car_bank.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/car_bank.sv
// Counter address register bank with load, step, offset and auto-increment burst.
// Read ports decode combinationally; err and burst_done are registered pulses.
module car_bank #(
  parameter int WIDTH   = 16,
  parameter int NUM_CAR = 5,
  parameter int SEL_W   = 3,
  parameter int BURST_W = 4
) (
  input  logic               clock,
  input  logic               clear,
  input  logic               addr_en,
  input  logic [SEL_W-1:0]   addr_sel,
  output logic [WIDTH-1:0]   addr_out,
  output logic               addr_oe,
  input  logic [WIDTH-1:0]   xbus_in,
  input  logic               ld_en,
  input  logic [SEL_W-1:0]   ld_sel,
  input  logic               xrd_en,
  input  logic [SEL_W-1:0]   xrd_sel,
  output logic [WIDTH-1:0]   xbus_out,
  output logic               xbus_oe,
  input  logic [SEL_W-1:0]   cnt_sel,
  input  logic               inc,
  input  logic               dec,
  input  logic               off_en,
  input  logic [7:0]         off,
  input  logic               burst_start,
  input  logic [SEL_W-1:0]   burst_sel,
  input  logic [BURST_W-1:0] burst_len,
  input  logic               burst_down,
  input  logic               burst_ready,
  output logic               burst_busy,
  output logic               burst_done,
  output logic               err
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t               state;
  logic [WIDTH-1:0]     car [NUM_CAR];
  logic [SEL_W-1:0]     b_sel;
  logic [BURST_W-1:0]   b_rem;
  logic                 b_down;

  logic                 busy;
  logic                 ld_ok;
  logic                 cnt_req;
  logic                 cnt_ok;
  logic                 ld_lock;
  logic                 cnt_lock;
  logic                 beat;
  logic                 last;
  logic                 start_ok;
  logic                 bad;
  logic [WIDTH-1:0]     off_ext;
  logic [WIDTH-1:0]     b_step;
  logic [WIDTH-1:0]     c_step;

  function automatic logic ok(input logic [SEL_W-1:0] s);
    return {1'b0, s} < (SEL_W+1)'(NUM_CAR);
  endfunction

  assign busy       = (state == BUSY);
  assign burst_busy = busy;

  assign ld_ok    = ld_en & ok(ld_sel);
  assign cnt_req  = inc | dec | off_en;
  assign cnt_ok   = cnt_req & ok(cnt_sel);
  // The burst CAR belongs to the burst engine until it finishes
  assign ld_lock  = busy & ld_en & (ld_sel == b_sel);
  assign cnt_lock = busy & cnt_req & (cnt_sel == b_sel);
  assign beat     = busy & burst_ready;
  assign last     = beat & (b_rem == BURST_W'(1));

  assign start_ok = ~busy & burst_start
                  & (burst_len != '0) & ok(burst_sel);

  assign bad = (burst_start & ~start_ok)
             | (ld_en & ~ok(ld_sel))
             | (cnt_req & ~ok(cnt_sel))
             | (addr_en & ~ok(addr_sel))
             | (xrd_en & ~ok(xrd_sel))
             | ld_lock
             | cnt_lock;

  assign off_ext = {{(WIDTH-8){off[7]}}, off};
  assign b_step  = b_down ? '1 : WIDTH'(1);
  assign c_step  = inc ? WIDTH'(1) : '1;

  always_comb begin
    addr_oe  = busy | (addr_en & ok(addr_sel));
    xbus_oe  = xrd_en & ok(xrd_sel);
    addr_out = '0;
    xbus_out = '0;
    for (int i = 0; i < NUM_CAR; i++) begin
      if (busy ? (b_sel == SEL_W'(i))
               : (addr_oe && addr_sel == SEL_W'(i)))
        addr_out = car[i];
      if (xbus_oe && xrd_sel == SEL_W'(i))
        xbus_out = car[i];
    end
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      for (int i = 0; i < NUM_CAR; i++)
        car[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CAR; i++) begin
        if (ld_ok && !ld_lock && ld_sel == SEL_W'(i))
          car[i] <= xbus_in;
        else if (beat && b_sel == SEL_W'(i))
          car[i] <= car[i] + b_step;
        else if (cnt_ok && !cnt_lock
                 && cnt_sel == SEL_W'(i) && off_en)
          car[i] <= car[i] + off_ext;
        else if (cnt_ok && !cnt_lock
                 && cnt_sel == SEL_W'(i) && (inc ^ dec))
          car[i] <= car[i] + c_step;
      end
    end
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state      <= IDLE;
      b_sel      <= '0;
      b_rem      <= '0;
      b_down     <= 1'b0;
      burst_done <= 1'b0;
      err        <= 1'b0;
    end else begin
      err        <= bad;
      burst_done <= last;
      case (state)
        IDLE: begin
          if (start_ok) begin
            state  <= BUSY;
            b_sel  <= burst_sel;
            b_rem  <= burst_len;
            b_down <= burst_down;
          end
        end
        BUSY: begin
          if (beat) begin
            b_rem <= b_rem - BURST_W'(1);
            if (b_rem == BURST_W'(1))
              state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
